cpu_path_mailbox: RTL and testbench

- Parametrised successor to the path-planner CPU driver.
- Holds the RISC-V path-planning core in reset and seeds its mailbox words over the external memory port.
- Releases the core, then captures every node it writes to the NODE mailbox into a DEPTH-entry FIFO.
- After the core writes DONE=1, streams the captured path to the motion controller over a valid/ready interface with a last-marker, a count and an overflow flag.

---
 rtl/cpu_path_mailbox.sv | 139 +++++++++++++
 tb/tb_cpu_path_mailbox.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_path_mailbox.sv
// cpu_path_mailbox: seeds a path-planning core's mailbox, captures its NODE stores in a FIFO, streams them after DONE.
// Ports: clk_50M/reset (async, active-high); start, start_node, end_node launch a run;
// cpu_mem_write/cpu_data_adr/cpu_write_data snoop core stores; cpu_reset holds the core;
// ext_mem_write/ext_data_adr/ext_write_data seed the mailbox words; path_node/path_valid/path_ready/path_last
// stream the captured path; path_count and overflow describe the run; busy is high outside IDLE;
// timeout is the sticky watchdog flag, built only when PATH_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module cpu_path_mailbox #(
  parameter int          NODE_W         = 5,
  parameter int          DEPTH          = 32,
  parameter logic [31:0] BASE_ADR       = 32'h0200_0000,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                     clk_50M,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NODE_W-1:0]        start_node,
  input  logic [NODE_W-1:0]        end_node,
  input  logic                     cpu_mem_write,
  input  logic [31:0]              cpu_data_adr,
  input  logic [31:0]              cpu_write_data,
  output logic                     cpu_reset,
  output logic                     ext_mem_write,
  output logic [31:0]              ext_data_adr,
  output logic [31:0]              ext_write_data,
  output logic [NODE_W-1:0]        path_node,
  output logic                     path_valid,
  input  logic                     path_ready,
  output logic                     path_last,
  output logic [$clog2(DEPTH):0]   path_count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, INIT, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [NODE_W-1:0] r_start, r_end;
  logic [2:0] r_init_cnt;
  logic [AW:0] r_wp, r_rp, r_count, w_occ;
  logic [NODE_W-1:0] r_mem [DEPTH];
  logic r_overflow;
  logic w_node_wr, w_done, w_full, w_empty, w_pop, w_tmo, w_ext_we;
  assign w_occ = r_wp - r_rp;
  assign w_full = w_occ == FULL_OCC;
  assign w_empty = w_occ == '0;
  assign w_node_wr = r_state == RUN && cpu_mem_write && cpu_data_adr == BASE_ADR + 32'h8;
  assign w_done = r_state == RUN && cpu_mem_write && cpu_data_adr == BASE_ADR + 32'hC && cpu_write_data == 32'h1;
  assign path_valid = r_state == DRAIN && !w_empty;
  assign w_pop = path_valid && path_ready;
  assign path_node = path_valid ? r_mem[r_rp[AW-1:0]] : '0;
  assign path_last = path_valid && w_occ == ONE;
  assign path_count = r_count;
  assign overflow = r_overflow;
  assign busy = r_state != IDLE;
  // cpu_reset is purely state-decoded so it rises/falls on the exact edge the state changes.
  assign cpu_reset = r_state != RUN;
  // Even INIT cycles write, odd cycles idle; r_init_cnt[2:1] selects the mailbox word.
  assign w_ext_we = r_state == INIT && !r_init_cnt[0];
  assign ext_mem_write = w_ext_we;
  assign ext_data_adr = w_ext_we ? BASE_ADR + {28'd0, r_init_cnt[2:1], 2'b00} : '0;
  assign ext_write_data = !w_ext_we ? '0 :
                          r_init_cnt[2:1] == 2'd0 ? 32'(r_start) :
                          r_init_cnt[2:1] == 2'd1 ? 32'(r_end) : '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? INIT : IDLE;
      INIT:    w_next = r_init_cnt == 3'd7 ? RUN : INIT;
      RUN:     w_next = w_done ? DRAIN : w_tmo ? IDLE : RUN;
      DRAIN:   w_next = w_empty ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_start <= '0;
      r_end <= '0;
      r_init_cnt <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_start <= start_node;
        r_end <= end_node;
        r_init_cnt <= '0;
        r_wp <= '0;
        r_rp <= '0;
        r_count <= '0;
        r_overflow <= 1'b0;
      end
      if (r_state == INIT) r_init_cnt <= r_init_cnt + 3'd1;
      if (w_node_wr && w_full) r_overflow <= 1'b1;
      if (w_node_wr && !w_full) begin
        r_wp <= r_wp + ONE;
        r_count <= r_count + ONE;
      end
      if (w_tmo) begin
        r_wp <= '0;
        r_rp <= '0;
        r_count <= '0;
      end
      if (w_pop) r_rp <= r_rp + ONE;
    end
  end
  always_ff @(posedge clk_50M) begin
    if (w_node_wr && !w_full) r_mem[r_wp[AW-1:0]] <= cpu_write_data[NODE_W-1:0];
  end
`ifdef PATH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmr;
  logic r_timeout;
  // Counter is held at zero outside RUN, so it restarts on every entry to RUN.
  assign w_tmo = r_state == RUN && !w_done && r_tmr == TW'(TIMEOUT_CYCLES - 1);
  assign timeout = r_timeout;
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_tmr <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmr <= r_state == RUN ? r_tmr + TW'(1) : '0;
      if (r_state == IDLE && start) r_timeout <= 1'b0;
      else if (w_tmo) r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES == 0;
  assign w_tmo = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_path_mailbox.sv
// tb_cpu_path_mailbox: directed bench for cpu_path_mailbox (default build).
module tb_cpu_path_mailbox;
  localparam int NW = 5;
  localparam int DEPTH = 32;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic clk_50M = 1'b0, reset = 1'b1, start = 1'b0;
  logic [NW-1:0] start_node = '0, end_node = '0;
  logic cpu_mem_write = 1'b0;
  logic [31:0] cpu_data_adr = '0, cpu_write_data = '0;
  logic path_ready = 1'b0;
  logic cpu_reset, ext_mem_write, path_valid, path_last, overflow, busy, timeout;
  logic [31:0] ext_data_adr, ext_write_data;
  logic [NW-1:0] path_node;
  logic [5:0] path_count;
  int checks = 0, failures = 0;
  logic [NW-1:0] exp_q[$];

  cpu_path_mailbox dut (
    .clk_50M(clk_50M), .reset(reset), .start(start), .start_node(start_node), .end_node(end_node),
    .cpu_mem_write(cpu_mem_write), .cpu_data_adr(cpu_data_adr), .cpu_write_data(cpu_write_data),
    .cpu_reset(cpu_reset), .ext_mem_write(ext_mem_write), .ext_data_adr(ext_data_adr),
    .ext_write_data(ext_write_data), .path_node(path_node), .path_valid(path_valid),
    .path_ready(path_ready), .path_last(path_last), .path_count(path_count),
    .overflow(overflow), .busy(busy), .timeout(timeout)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic tick;
    @(posedge clk_50M);
    #1;
  endtask

  task automatic launch(input logic [NW-1:0] s, input logic [NW-1:0] e);
    start = 1'b1;
    start_node = s;
    end_node = e;
    tick();
    start = 1'b0;
  endtask

  task automatic cpu_wr(input logic [31:0] adr, input logic [31:0] data);
    cpu_mem_write = 1'b1;
    cpu_data_adr = adr;
    cpu_write_data = data;
    tick();
    cpu_mem_write = 1'b0;
  endtask

  task automatic drain(input bit bp);
    int idx = 0;
    int k = 0;
    int n = exp_q.size();
    logic r;
    while (idx < n && k < 4 * n + 8) begin
      r = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      path_ready = r;
      checks++;
      if ({path_valid, path_last, path_node} !== {1'b1, idx == n - 1, exp_q[idx]}) begin
        failures++;
        $display("FAIL stream[%0d] got v=%b l=%b n=%0d want v=1 l=%b n=%0d", idx, path_valid, path_last, path_node, idx == n - 1, exp_q[idx]);
      end
      tick();
      if (r) idx++;
      k++;
    end
    path_ready = 1'b0;
    checks++;
    if (idx != n) begin failures++; $display("FAIL stream_count got=%0d want=%0d", idx, n); end
    checks++;
    if (path_valid !== 1'b0) begin failures++; $display("FAIL valid_after_stream got=%b want=0", path_valid); end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_stream got=%b want=0", busy); end
  endtask

  task automatic test_reset;
    tick();
    checks++;
    if ({cpu_reset, ext_mem_write, ext_data_adr, ext_write_data, path_valid, path_last, path_node, path_count, overflow, busy, timeout} !== {1'b1, 1'b0, 64'd0, 2'b00, 5'd0, 6'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset_state got cr=%b we=%b v=%b cnt=%0d ov=%b busy=%b to=%b want cr=1 rest 0", cpu_reset, ext_mem_write, path_valid, path_count, overflow, busy, timeout);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_init;
    logic [64:0] exp;
    launch(5'd3, 5'd17);
    for (int i = 0; i < 8; i++) begin
      exp = (i % 2 == 1) ? 65'd0 :
            i == 0 ? {1'b1, BASE, 32'd3} :
            i == 2 ? {1'b1, BASE + 32'h4, 32'd17} :
            i == 4 ? {1'b1, BASE + 32'h8, 32'd0} : {1'b1, BASE + 32'hC, 32'd0};
      checks++;
      if ({ext_mem_write, ext_data_adr, ext_write_data} !== exp || cpu_reset !== 1'b1) begin
        failures++;
        $display("FAIL init_cycle%0d got we=%b a=%h d=%h cr=%b want we=%b a=%h d=%h cr=1", i + 1, ext_mem_write, ext_data_adr, ext_write_data, cpu_reset, exp[64], exp[63:32], exp[31:0]);
      end
      tick();
    end
    checks++;
    if ({cpu_reset, busy, ext_mem_write} !== 3'b010) begin
      failures++;
      $display("FAIL run_entry got cr=%b busy=%b we=%b want cr=0 busy=1 we=0", cpu_reset, busy, ext_mem_write);
    end
  endtask

  task automatic test_capture_stream;
    cpu_wr(BASE + 32'h8, 32'd3);
    cpu_wr(BASE + 32'h8, 32'hABCD_0008);
    cpu_wr(BASE + 32'h8, 32'd12);
    cpu_wr(BASE + 32'h8, 32'd17);
    cpu_wr(BASE + 32'h4, 32'd9);
    cpu_wr(BASE + 32'h10, 32'd1);
    cpu_wr(BASE + 32'hC, 32'd2);
    checks++;
    if ({path_count, cpu_reset, busy, path_valid} !== {6'd4, 3'b010}) begin
      failures++;
      $display("FAIL run_capture got cnt=%0d cr=%b busy=%b v=%b want cnt=4 cr=0 busy=1 v=0", path_count, cpu_reset, busy, path_valid);
    end
    cpu_wr(BASE + 32'hC, 32'd1);
    checks++;
    if ({path_count, overflow, cpu_reset} !== {6'd4, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL done got cnt=%0d ov=%b cr=%b want cnt=4 ov=0 cr=1", path_count, overflow, cpu_reset);
    end
    exp_q = '{5'd3, 5'd8, 5'd12, 5'd17};
    drain(1'b0);
    checks++;
    if (path_count !== 6'd4) begin failures++; $display("FAIL count_hold got=%0d want=4", path_count); end
  endtask

  task automatic test_back_to_back;
    launch(5'd1, 5'd2);
    repeat (8) tick();
    cpu_wr(BASE + 32'h8, 32'd5);
    cpu_wr(BASE + 32'h8, 32'd6);
    cpu_wr(BASE + 32'h8, 32'd7);
    cpu_wr(BASE + 32'h8, 32'd9);
    cpu_wr(BASE + 32'hC, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_wr(BASE + 32'h8, 32'd30);
    checks++;
    if ({busy, path_valid, path_node, path_count} !== {2'b11, 5'd5, 6'd4}) begin
      failures++;
      $display("FAIL drain_ignores got busy=%b v=%b n=%0d cnt=%0d want busy=1 v=1 n=5 cnt=4", busy, path_valid, path_node, path_count);
    end
    exp_q = '{5'd5, 5'd6, 5'd7, 5'd9};
    drain(1'b1);
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_hold got busy=%b want=0", busy); end
  endtask

  task automatic test_overflow;
    launch(5'd0, 5'd31);
    checks++;
    if ({overflow, path_count} !== {1'b0, 6'd0}) begin
      failures++;
      $display("FAIL start_clears got ov=%b cnt=%0d want ov=0 cnt=0", overflow, path_count);
    end
    repeat (8) tick();
    exp_q = {};
    for (int i = 0; i < DEPTH + 2; i++) begin
      cpu_wr(BASE + 32'h8, 32'((i * 7 + 1) % 32));
      if (i < DEPTH) exp_q.push_back(5'((i * 7 + 1) % 32));
    end
    cpu_wr(BASE + 32'hC, 32'd1);
    checks++;
    if ({overflow, path_count} !== {1'b1, 6'd32}) begin
      failures++;
      $display("FAIL overflow got ov=%b cnt=%0d want ov=1 cnt=32", overflow, path_count);
    end
    drain(1'b0);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_zero_entry;
    launch(5'd4, 5'd4);
    repeat (8) tick();
    cpu_wr(BASE + 32'hC, 32'd1);
    checks++;
    if ({busy, path_valid, path_count} !== {2'b10, 6'd0}) begin
      failures++;
      $display("FAIL zero_drain got busy=%b v=%b cnt=%0d want busy=1 v=0 cnt=0", busy, path_valid, path_count);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_idle got busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_init;
    launch(5'd6, 5'd7);
    tick();
    tick();
    checks++;
    if (ext_mem_write !== 1'b1) begin failures++; $display("FAIL init_write3 got we=%b want=1", ext_mem_write); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({cpu_reset, ext_mem_write, ext_data_adr, ext_write_data, busy} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_abort got cr=%b we=%b a=%h d=%h busy=%b want cr=1 we=0 a=0 d=0 busy=0", cpu_reset, ext_mem_write, ext_data_adr, ext_write_data, busy);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({cpu_reset, busy, path_count} !== {2'b10, 6'd0}) begin
      failures++;
      $display("FAIL post_abort got cr=%b busy=%b cnt=%0d want cr=1 busy=0 cnt=0", cpu_reset, busy, path_count);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_capture_stream();
    test_back_to_back();
    test_overflow();
    test_zero_entry();
    test_reset_mid_init();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
